// File: rtl/demux8_out.sv
// Purpose: steers one W-bit producer stream into one of 8 one-entry output registers.
// Latency: 1 cycle from input transfer to out_valid/out_data on the selected channel.
// Backpressure: in_ready drops only when the selected channel holds data that is not draining.
module demux8_out #(
   parameter int W   = 64,
   parameter int NCH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [2:0]   SelDemux8,
   output logic [7:0]   out_valid,
   input  logic [7:0]   out_ready,
   output logic [W-1:0] out_data_a,
   output logic [W-1:0] out_data_b,
   output logic [W-1:0] out_data_c,
   output logic [W-1:0] out_data_d,
   output logic [W-1:0] out_data_e,
   output logic [W-1:0] out_data_f,
   output logic [W-1:0] out_data_g,
   output logic [W-1:0] out_data_h,
   output logic [3:0]   out_count
);

   logic [W-1:0]   data_q [NCH];
   logic [NCH-1:0] valid_q;
   logic [NCH-1:0] valid_d;
   logic [NCH-1:0] load;
   logic [NCH-1:0] drain;
   logic [3:0]     count_q;
   logic [3:0]     count_d;
   logic           in_xfer;

   // The selected channel accepts when empty or emptying this same cycle.
   assign in_ready = ~valid_q[SelDemux8] | out_ready[SelDemux8];
   assign in_xfer  = in_valid & in_ready;

   // Per-channel load/drain decode and the next valid vector with its popcount.
   always_comb begin
      load    = '0;
      drain   = valid_q & out_ready;
      count_d = '0;
      if (in_xfer) begin
         load[SelDemux8] = 1'b1;
      end
      // A load wins over a same-cycle drain, so the channel stays valid with fresh data.
      valid_d = (valid_q & ~drain) | load;
      for (int i = 0; i < NCH; i++) begin
         count_d = count_d + {3'b000, valid_d[i]};
      end
   end

   // Channel registers; reset discards everything, including a same-cycle accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         for (int i = 0; i < NCH; i++) begin
            if (load[i]) begin
               data_q[i] <= in_data;
            end
         end
      end
   end

   assign out_valid  = valid_q;
   assign out_count  = count_q;
   assign out_data_a = data_q[0];
   assign out_data_b = data_q[1];
   assign out_data_c = data_q[2];
   assign out_data_d = data_q[3];
   assign out_data_e = data_q[4];
   assign out_data_f = data_q[5];
   assign out_data_g = data_q[6];
   assign out_data_h = data_q[7];

endmodule
